// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if
//   Bundles every handshake and bus signal of regfile_port_arbiter.
//   Requester C (core decoder): c_req/c_rw/c_addr/c_wdata -> c_gnt/c_rvalid.
//   Requester H (host loader) : h_req/h_rw/h_addr/h_wdata/h_lock -> h_gnt/h_rvalid.
//   Shared                    : rdata, lock_err.
//   Register-file side        : rf_cs/rf_rw/rf_addr/rf_wdata -> rf_rdata.
//   Optional (REGARB_STATS_EN): gnt_cnt_c, gnt_cnt_h grant counters.
//   Modports: slave  = arbiter view (serves requests, drives the register file)
//             master = environment view (requesters plus register file)
interface regfile_port_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
`ifdef REGARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
);

  logic              c_req;
  logic              c_rw;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;

  logic              h_req;
  logic              h_rw;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_lock;
  logic              h_gnt;
  logic              h_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              lock_err;

  logic              rf_cs;
  logic              rf_rw;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

`ifdef REGARB_STATS_EN
  logic [CNT_W-1:0]  gnt_cnt_c;
  logic [CNT_W-1:0]  gnt_cnt_h;

  modport slave (
    input  c_req, c_rw, c_addr, c_wdata,
    input  h_req, h_rw, h_addr, h_wdata, h_lock,
    input  rf_rdata,
    output c_gnt, c_rvalid, h_gnt, h_rvalid, rdata, lock_err,
    output rf_cs, rf_rw, rf_addr, rf_wdata,
    output gnt_cnt_c, gnt_cnt_h
  );

  modport master (
    output c_req, c_rw, c_addr, c_wdata,
    output h_req, h_rw, h_addr, h_wdata, h_lock,
    output rf_rdata,
    input  c_gnt, c_rvalid, h_gnt, h_rvalid, rdata, lock_err,
    input  rf_cs, rf_rw, rf_addr, rf_wdata,
    input  gnt_cnt_c, gnt_cnt_h
  );
`else
  modport slave (
    input  c_req, c_rw, c_addr, c_wdata,
    input  h_req, h_rw, h_addr, h_wdata, h_lock,
    input  rf_rdata,
    output c_gnt, c_rvalid, h_gnt, h_rvalid, rdata, lock_err,
    output rf_cs, rf_rw, rf_addr, rf_wdata
  );

  modport master (
    output c_req, c_rw, c_addr, c_wdata,
    output h_req, h_rw, h_addr, h_wdata, h_lock,
    output rf_rdata,
    input  c_gnt, c_rvalid, h_gnt, h_rvalid, rdata, lock_err,
    input  rf_cs, rf_rw, rf_addr, rf_wdata
  );
`endif

endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares the single register-file port between the core decoder (C) and the
//   host/debug loader (H). Round-robin between C and H; H may lock the port for
//   atomic multi-word loads, bounded to LOCK_MAX consecutive cycles. A forced
//   unlock sets the sticky lock_err and ignores h_lock until it is seen low.
//   Ports: clk, rst (synchronous, active-low), bus (regfile_port_arbiter_if.slave).
//   Optional feature macro: REGARB_STATS_EN adds saturating grant counters
//   gnt_cnt_c / gnt_cnt_h (CNT_W bits) on the interface.
module regfile_port_arbiter #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LOCK_MAX = 32
`ifdef REGARB_STATS_EN
  , parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_port_arbiter_if.slave  bus
);

  localparam int unsigned LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_C,
    ARB_H,
    ARB_LOCK
  } arb_state_t;

  arb_state_t        state;
  logic              c_gnt_q, h_gnt_q;
  logic              c_rvalid_q, h_rvalid_q;
  logic              lock_err_q;
  logic              rf_cs_q, rf_rw_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              rr_h;      // 1: H wins the next tie
  logic              lock_ign;  // h_lock masked after a forced unlock
  logic [LCW-1:0]    lock_cnt;  // cycles spent in ARB_LOCK so far

  logic c_elig, h_elig;
  logic pick_c, pick_h;
  logic to_lock, lock_rel, lock_drop;

  // A requester whose gnt is high this cycle has just been consumed.
  always_comb begin
    c_elig    = bus.c_req && !c_gnt_q;
    h_elig    = bus.h_req && !h_gnt_q;
    pick_c    = 1'b0;
    pick_h    = 1'b0;
    to_lock   = 1'b0;
    lock_rel  = 1'b0;
    lock_drop = 1'b0;
    if (state == ARB_LOCK) begin
      if (!bus.h_lock) begin
        // Voluntary release: arbitrate with the pointer on C.
        lock_rel = 1'b1;
        pick_c   = c_elig;
        pick_h   = h_elig && !c_elig;
      end else if (lock_cnt == LCW'(LOCK_MAX - 1)) begin
        // LOCK_MAX-th cycle in lock: forced release, C first.
        lock_drop = 1'b1;
        pick_c    = c_elig;
        pick_h    = h_elig && !c_elig;
      end else begin
        pick_h  = h_elig;
        to_lock = 1'b1;
      end
    end else begin
      if (c_elig && h_elig) begin
        pick_c = !rr_h;
        pick_h = rr_h;
      end else begin
        pick_c = c_elig;
        pick_h = h_elig;
      end
      to_lock = pick_h && bus.h_lock && !lock_ign;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      c_gnt_q    <= 1'b0;
      h_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      lock_err_q <= 1'b0;
      rf_cs_q    <= 1'b0;
      rf_rw_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      rr_h       <= 1'b0;
      lock_ign   <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      c_gnt_q    <= pick_c;
      h_gnt_q    <= pick_h;
      // Read tag: the command issued last cycle is a read of that owner.
      c_rvalid_q <= c_gnt_q && rf_rw_q;
      h_rvalid_q <= h_gnt_q && rf_rw_q;

      if (pick_c) begin
        rf_cs_q    <= 1'b1;
        rf_rw_q    <= bus.c_rw;
        rf_addr_q  <= bus.c_addr;
        rf_wdata_q <= bus.c_wdata;
      end else if (pick_h) begin
        rf_cs_q    <= 1'b1;
        rf_rw_q    <= bus.h_rw;
        rf_addr_q  <= bus.h_addr;
        rf_wdata_q <= bus.h_wdata;
      end else begin
        rf_cs_q    <= 1'b0;
        rf_rw_q    <= 1'b0;
      end

      if (pick_c)
        rr_h <= 1'b1;
      else if (pick_h || lock_rel || lock_drop)
        rr_h <= 1'b0;

      if (to_lock)
        state <= ARB_LOCK;
      else if (pick_c)
        state <= ARB_C;
      else if (pick_h)
        state <= ARB_H;
      else
        state <= ARB_IDLE;

      if (state == ARB_LOCK && to_lock)
        lock_cnt <= lock_cnt + 1'b1;
      else
        lock_cnt <= '0;

      if (lock_drop)
        lock_err_q <= 1'b1;

      if (lock_drop)
        lock_ign <= 1'b1;
      else if (!bus.h_lock)
        lock_ign <= 1'b0;
    end
  end

  assign bus.c_gnt    = c_gnt_q;
  assign bus.h_gnt    = h_gnt_q;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.h_rvalid = h_rvalid_q;
  assign bus.lock_err = lock_err_q;
  assign bus.rf_cs    = rf_cs_q;
  assign bus.rf_rw    = rf_rw_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_wdata = rf_wdata_q;
  // Read data passes straight through while a result is owned; zero otherwise
  // so a read in flight at reset cannot leak out.
  assign bus.rdata    = (c_rvalid_q || h_rvalid_q) ? bus.rf_rdata : '0;

`ifdef REGARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt_c_q, gnt_cnt_h_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_cnt_c_q <= '0;
      gnt_cnt_h_q <= '0;
    end else begin
      if (pick_c && gnt_cnt_c_q != '1)
        gnt_cnt_c_q <= gnt_cnt_c_q + 1'b1;
      if (pick_h && gnt_cnt_h_q != '1)
        gnt_cnt_h_q <= gnt_cnt_h_q + 1'b1;
    end
  end

  assign bus.gnt_cnt_c = gnt_cnt_c_q;
  assign bus.gnt_cnt_h = gnt_cnt_h_q;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
//   Directed bench for regfile_port_arbiter with a behavioural register file
//   (16 words, read data one cycle after a read select).
module tb_regfile_port_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned LM = 32;
  localparam int unsigned OW = 7 + AW + 2 * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  regfile_port_arbiter_if #(
    .ADDR_W(AW),
    .DATA_W(DW)
`ifdef REGARB_STATS_EN
    , .CNT_W(16)
`endif
  ) bus ();

  regfile_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .LOCK_MAX(LM)
`ifdef REGARB_STATS_EN
    , .CNT_W(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Register file model; load_rf preloads mem[i] = A000+i, mem[4] = 1234.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rf_q;
  logic          load_rf = 1'b1;

  always @(posedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(16'hA000 + i);
      mem[4] <= 16'h1234;
      rf_q   <= '0;
    end else if (bus.rf_cs) begin
      if (bus.rf_rw) rf_q <= mem[bus.rf_addr];
      else           mem[bus.rf_addr] <= bus.rf_wdata;
    end
  end
  assign bus.rf_rdata = rf_q;

  logic [OW-1:0] outs;
  assign outs = {bus.c_gnt, bus.c_rvalid, bus.h_gnt, bus.h_rvalid, bus.lock_err,
                 bus.rf_cs, bus.rf_rw, bus.rf_addr, bus.rf_wdata, bus.rdata};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_rw = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.h_req = 1'b0; bus.h_rw = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.h_lock = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    load_rf = 1'b1;
    repeat (3) tick();
    load_rf = 1'b0;
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got %h want 0", outs);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (outs !== '0) begin
        miscompares++;
        $display("FAIL idle_no_req[%0d]: got %h want 0", i, outs);
      end
    end
`ifdef REGARB_STATS_EN
    vectors++;
    if ({bus.gnt_cnt_c, bus.gnt_cnt_h} !== 32'h0) begin
      miscompares++;
      $display("FAIL stats_reset: got %h want 0", {bus.gnt_cnt_c, bus.gnt_cnt_h});
    end
`endif
  endtask

  task automatic test_c_read();
    bus.c_req = 1'b1; bus.c_rw = 1'b1; bus.c_addr = 4'd4;
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt, bus.rf_cs, bus.rf_rw, bus.rf_addr, bus.c_rvalid}
        !== {1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL c_read_grant: got %b want 1011_0100_0",
               {bus.c_gnt, bus.h_gnt, bus.rf_cs, bus.rf_rw, bus.rf_addr, bus.c_rvalid});
    end
    bus.c_req = 1'b0;
    tick();
    vectors++;
    if ({bus.c_rvalid, bus.h_rvalid, bus.c_gnt, bus.rf_cs, bus.rf_rw, bus.rf_addr, bus.rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 16'h1234}) begin
      miscompares++;
      $display("FAIL c_read_data: got cv=%b hv=%b gnt=%b cs=%b rw=%b addr=%h rdata=%h want 1 0 0 0 0 4 1234",
               bus.c_rvalid, bus.h_rvalid, bus.c_gnt, bus.rf_cs, bus.rf_rw, bus.rf_addr, bus.rdata);
    end
    tick();
    vectors++;
    if ({bus.c_rvalid, bus.h_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL c_read_after: got rvalid %b want 00", {bus.c_rvalid, bus.h_rvalid});
    end
`ifdef REGARB_STATS_EN
    vectors++;
    if (bus.gnt_cnt_c !== 16'd1) begin
      miscompares++;
      $display("FAIL stats_c: got %0d want 1", bus.gnt_cnt_c);
    end
`endif
  endtask

  task automatic test_round_robin();
    logic exp_c;
    rst = 1'b0;
    bus.c_req = 1'b1; bus.c_rw = 1'b1; bus.c_addr = 4'd1;
    bus.h_req = 1'b1; bus.h_rw = 1'b1; bus.h_addr = 4'd2; bus.h_lock = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_c = (i % 2 == 0);
      vectors++;
      if ({bus.c_gnt, bus.h_gnt, bus.rf_cs} !== {exp_c, !exp_c, 1'b1}) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got cg=%b hg=%b cs=%b want %b %b 1",
                 i, bus.c_gnt, bus.h_gnt, bus.rf_cs, exp_c, !exp_c);
      end
      if (i > 0) begin
        vectors++;
        if ({bus.c_rvalid, bus.h_rvalid, bus.rdata}
            !== {!exp_c, exp_c, (exp_c ? 16'hA002 : 16'hA001)}) begin
          miscompares++;
          $display("FAIL rr_read[%0d]: got cv=%b hv=%b rdata=%h want %b %b %h",
                   i, bus.c_rvalid, bus.h_rvalid, bus.rdata, !exp_c, exp_c,
                   (exp_c ? 16'hA002 : 16'hA001));
        end
      end
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_lock();
    bus.h_req = 1'b1; bus.h_rw = 1'b0; bus.h_addr = 4'd0; bus.h_wdata = '0; bus.h_lock = 1'b1;
    tick();
    vectors++;
    if ({bus.h_gnt, bus.c_gnt, bus.rf_rw, bus.rf_addr, bus.rf_wdata}
        !== {1'b1, 1'b0, 1'b0, 4'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL lock_enter: got hg=%b cg=%b rw=%b addr=%h wd=%h want 1 0 0 0 0",
               bus.h_gnt, bus.c_gnt, bus.rf_rw, bus.rf_addr, bus.rf_wdata);
    end
    bus.c_req = 1'b1; bus.c_rw = 1'b1; bus.c_addr = 4'd9;
    for (int w = 1; w < 6; w++) begin
      bus.h_addr = AW'(w); bus.h_wdata = DW'(w);
      tick();
      vectors++;
      if ({bus.c_gnt, bus.h_gnt} !== 2'b00) begin
        miscompares++;
        $display("FAIL lock_gap[%0d]: got cg=%b hg=%b want 0 0", w, bus.c_gnt, bus.h_gnt);
      end
      tick();
      vectors++;
      if ({bus.c_gnt, bus.h_gnt, bus.rf_cs, bus.rf_rw, bus.rf_addr, bus.rf_wdata}
          !== {1'b0, 1'b1, 1'b1, 1'b0, AW'(w), DW'(w)}) begin
        miscompares++;
        $display("FAIL lock_word[%0d]: got cg=%b hg=%b cs=%b rw=%b addr=%h wd=%h",
                 w, bus.c_gnt, bus.h_gnt, bus.rf_cs, bus.rf_rw, bus.rf_addr, bus.rf_wdata);
      end
    end
    bus.h_req = 1'b0; bus.h_lock = 1'b0;
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt, bus.rf_addr, bus.lock_err} !== {1'b1, 1'b0, 4'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL lock_release: got cg=%b hg=%b addr=%h err=%b want 1 0 9 0",
               bus.c_gnt, bus.h_gnt, bus.rf_addr, bus.lock_err);
    end
    bus.c_req = 1'b0;
    repeat (2) tick();
    for (int a = 0; a < 6; a++) begin
      vectors++;
      if (mem[a] !== DW'(a)) begin
        miscompares++;
        $display("FAIL lock_mem[%0d]: got %h want %h", a, mem[a], DW'(a));
      end
    end
  endtask

  task automatic test_lock_max();
    bus.h_req = 1'b1; bus.h_rw = 1'b0; bus.h_addr = 4'd7; bus.h_wdata = 16'h7777; bus.h_lock = 1'b1;
    tick();
    vectors++;
    if ({bus.h_gnt, bus.lock_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL lmax_enter: got hg=%b err=%b want 1 0", bus.h_gnt, bus.lock_err);
    end
    bus.c_req = 1'b1; bus.c_rw = 1'b1; bus.c_addr = 4'd4;
    for (int k = 1; k < 32; k++) begin
      tick();
      vectors++;
      if ({bus.c_gnt, bus.h_gnt, bus.lock_err} !== {1'b0, (k % 2 == 0), 1'b0}) begin
        miscompares++;
        $display("FAIL lmax_hold[%0d]: got cg=%b hg=%b err=%b want 0 %b 0",
                 k, bus.c_gnt, bus.h_gnt, bus.lock_err, (k % 2 == 0));
      end
    end
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt, bus.lock_err} !== 3'b101) begin
      miscompares++;
      $display("FAIL lmax_drop: got cg=%b hg=%b err=%b want 1 0 1", bus.c_gnt, bus.h_gnt, bus.lock_err);
    end
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL lmax_h_after: got cg=%b hg=%b want 0 1", bus.c_gnt, bus.h_gnt);
    end
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt, bus.lock_err} !== 3'b101) begin
      miscompares++;
      $display("FAIL lmax_lock_ignored: got cg=%b hg=%b err=%b want 1 0 1", bus.c_gnt, bus.h_gnt, bus.lock_err);
    end
    bus.c_req = 1'b0; bus.h_req = 1'b0; bus.h_lock = 1'b0;
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt} !== 2'b00) begin
      miscompares++;
      $display("FAIL lmax_idle: got cg=%b hg=%b want 0 0", bus.c_gnt, bus.h_gnt);
    end
    bus.h_req = 1'b1; bus.h_lock = 1'b1;
    tick();
    vectors++;
    if (bus.h_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL lmax_relock: got hg=%b want 1", bus.h_gnt);
    end
    bus.c_req = 1'b1;
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt} !== 2'b00) begin
      miscompares++;
      $display("FAIL lmax_relock_wait: got cg=%b hg=%b want 0 0", bus.c_gnt, bus.h_gnt);
    end
    tick();
    vectors++;
    if ({bus.c_gnt, bus.h_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL lmax_relock_h: got cg=%b hg=%b want 0 1", bus.c_gnt, bus.h_gnt);
    end
    bus.h_req = 1'b0; bus.h_lock = 1'b0;
    tick();
    vectors++;
    if ({bus.c_gnt, bus.lock_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL lmax_release: got cg=%b err=%b want 1 1", bus.c_gnt, bus.lock_err);
    end
    bus.c_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_read();
    bus.h_req = 1'b1; bus.h_rw = 1'b1; bus.h_addr = 4'd4; bus.h_lock = 1'b0;
    tick();
    vectors++;
    if ({bus.h_gnt, bus.rf_rw} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_read_grant: got hg=%b rw=%b want 1 1", bus.h_gnt, bus.rf_rw);
    end
    rst = 1'b0;
    bus.h_req = 1'b0;
    tick();
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL mid_read_reset: got %h want 0", outs);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL mid_read_after: got %h want 0", outs);
    end
    // A write issued just before reset still lands in the register file.
    bus.h_req = 1'b1; bus.h_rw = 1'b0; bus.h_addr = 4'd3; bus.h_wdata = 16'h3333;
    tick();
    rst = 1'b0;
    bus.h_req = 1'b0;
    tick();
    vectors++;
    if (mem[3] !== 16'h3333) begin
      miscompares++;
      $display("FAIL write_before_reset: got %h want 3333", mem[3]);
    end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_c_read();
    test_round_robin();
    test_lock();
    test_lock_max();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
